// File: rtl/cram_readout_pkg.sv
// Shared constants for the CoMeFa port-2 readout path: geometry defaults,
// readout FSM encodings and the precision clamp.
package cram_readout_pkg;

   localparam int CRO_AWIDTH       = 9;
   localparam int CRO_DWIDTH       = 40;
   localparam int CRO_NUM_RAMS     = 4;
   localparam int RF_MAX_PRECISION = 8;

   localparam logic [1:0] CRO_IDLE  = 2'd0;
   localparam logic [1:0] CRO_READ  = 2'd1;
   localparam logic [1:0] CRO_DRAIN = 2'd2;

   // A precision of 0, or anything above the hardware maximum, means "full width".
   function automatic logic [3:0] cro_eff_prec(input logic [3:0] prec, input int max_prec);
      if (prec == 4'd0 || int'(prec) > max_prec) return 4'(max_prec);
      return prec;
   endfunction

endpackage

// File: rtl/cram_transpose_buf.sv
// Bit-plane to element transpose store: one row per plane write, read back
// four zero-extended elements at a time as a packed 32-bit word.
module cram_transpose_buf
   import cram_readout_pkg::*;
#(
   parameter int DWIDTH   = CRO_DWIDTH,
   parameter int MAX_PREC = RF_MAX_PRECISION,
   parameter int WW       = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [3:0]        wr_k,
   input  logic [DWIDTH-1:0] wr_row,
   input  logic [WW-1:0]     rd_w,
   output logic [31:0]       rd_word
);

   localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

   logic [MAX_PREC-1:0] elem [DWIDTH];
   logic [IW-1:0]       idx;

   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         for (int j = 0; j < DWIDTH; j++) elem[j] <= '0;
      end else if (wr_en) begin
         for (int j = 0; j < DWIDTH; j++) begin
            for (int b = 0; b < MAX_PREC; b++) begin
               if (wr_k == 4'(b)) elem[j][b] <= wr_row[j];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      idx     = '0;
      for (int l = 0; l < 4; l++) begin
         if (4 * int'(rd_w) + l < DWIDTH) begin
            idx = IW'(4 * int'(rd_w) + l);
            rd_word[8*l +: MAX_PREC] = elem[idx];
         end
      end
   end

endmodule

// File: rtl/cram_readout.sv
// Reads a bit-serial result field from one CoMeFa RAM's port 2, transposes it
// and streams the elements out as packed 32-bit words over valid/ready.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   CRO_IDLE  | waiting for start
//   CRO_READ  | issuing P row reads, capturing each plane one cycle later
//   CRO_DRAIN | presenting DWIDTH/4 words, advancing on handshake
module cram_readout
   import cram_readout_pkg::*;
#(
   parameter int AWIDTH   = CRO_AWIDTH,
   parameter int DWIDTH   = CRO_DWIDTH,
   parameter int NUM_RAMS = CRO_NUM_RAMS,
   parameter int MAX_PREC = RF_MAX_PRECISION
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [AWIDTH-1:0]          base_addr,
   input  logic [3:0]                 prec,
   input  logic [1:0]                 ram_sel,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_en,
   output logic [AWIDTH-1:0]          rd_addr,
   input  logic [NUM_RAMS*DWIDTH-1:0] q2_all,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data
);

   localparam int NWORDS = DWIDTH / 4;
   localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   logic [1:0]        state;
   logic [3:0]        p_q;
   logic [1:0]        sel_q;
   logic [3:0]        k;
   logic [3:0]        cap_k;
   logic              cap_en;
   logic [WW-1:0]     w;
   logic [DWIDTH-1:0] row;
   logic              accept;
   logic              last_cap;
   logic              last_word;

   assign accept    = (state == CRO_IDLE) && start;
   assign last_cap  = cap_en && (cap_k == p_q - 4'd1);
   assign last_word = out_valid && out_ready && (w == WW'(NWORDS - 1));

   always_comb begin
      row = '0;
      for (int r = 0; r < NUM_RAMS; r++) begin
         if (sel_q == r[1:0]) row = q2_all[r*DWIDTH +: DWIDTH];
      end
   end

   // Port 2 has one cycle of read latency, so capture trails issue by a cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= CRO_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         p_q       <= '0;
         sel_q     <= '0;
         k         <= '0;
         cap_k     <= '0;
         cap_en    <= 1'b0;
         w         <= '0;
      end else begin
         done   <= 1'b0;
         cap_en <= rd_en;
         cap_k  <= k;
         case (state)
            CRO_IDLE: begin
               if (start) begin
                  state   <= CRO_READ;
                  busy    <= 1'b1;
                  p_q     <= cro_eff_prec(prec, MAX_PREC);
                  sel_q   <= ram_sel;
                  k       <= '0;
                  w       <= '0;
                  rd_en   <= 1'b1;
                  rd_addr <= base_addr;
               end
            end
            CRO_READ: begin
               if (rd_en) begin
                  if (k == p_q - 4'd1) begin
                     rd_en <= 1'b0;
                  end else begin
                     k       <= k + 4'd1;
                     rd_addr <= rd_addr + AWIDTH'(1);
                  end
               end
               if (last_cap) begin
                  state     <= CRO_DRAIN;
                  out_valid <= 1'b1;
               end
            end
            CRO_DRAIN: begin
               if (last_word) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= CRO_IDLE;
               end else if (out_valid && out_ready) begin
                  w <= w + WW'(1);
               end
            end
            default: state <= CRO_IDLE;
         endcase
      end
   end

   cram_transpose_buf #(
      .DWIDTH   (DWIDTH),
      .MAX_PREC (MAX_PREC),
      .WW       (WW)
   ) u_tbuf (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (accept),
      .wr_en   (cap_en),
      .wr_k    (cap_k),
      .wr_row  (row),
      .rd_w    (w),
      .rd_word (out_data)
   );

endmodule

// File: tb/tb_cram_readout.sv
// Self-checking bench for cram_readout: synchronous port-2 RAM model plus a
// plane-to-element reference computed directly from memory contents.
module tb_cram_readout;

   localparam int AW = 9;
   localparam int DW = 40;
   localparam int NR = 4;
   localparam int NW = DW / 4;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [AW-1:0]     base_addr = '0;
   logic [3:0]        prec = '0;
   logic [1:0]        ram_sel = '0;
   logic              busy, done, rd_en, out_valid;
   logic [AW-1:0]     rd_addr;
   logic [NR*DW-1:0]  q2_all = '0;
   logic              out_ready = 1'b0;
   logic [31:0]       out_data;

   logic [DW-1:0]     mem [NR][1 << AW];
   logic [31:0]       exp_w [NW];
   logic [31:0]       got_w [$];
   int                first_v, done_c;
   int                n_cmp = 0;
   int                n_err = 0;

   always #5 clk = ~clk;

   cram_readout dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .prec      (prec),
      .ram_sel   (ram_sel),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .q2_all    (q2_all),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Port 2 of every RAM: registered read, data one cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en)
         for (int r = 0; r < NR; r++) q2_all[r*DW +: DW] <= mem[r][rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Element j is the P-bit number whose bit k sits in column j of row base+k.
   function automatic void build_exp(input logic [AW-1:0] base, input int p, input int sel);
      logic [7:0]    e [DW];
      logic [AW-1:0] a;
      for (int j = 0; j < DW; j++) begin
         e[j] = 8'd0;
         for (int b = 0; b < p; b++) begin
            a = base + AW'(b);
            e[j][b] = mem[sel][a][j];
         end
      end
      for (int i = 0; i < NW; i++)
         exp_w[i] = {e[4*i+3], e[4*i+2], e[4*i+1], e[4*i]};
   endfunction

   // rmode: 0 ready high, 1 random ready, 2 pattern 1,0,0,...
   task automatic run_xfer(input logic [AW-1:0] base, input logic [3:0] pr, input logic [1:0] sel,
                           input int rmode, input bit drop, input int rst_after);
      int            p, cyc, nrd, nhs;
      bit            stall, fin;
      logic [31:0]   pdata;
      logic [AW-1:0] ea;
      p = (pr == 4'd0 || pr > 4'd8) ? 8 : int'(pr);
      build_exp(base, p, int'(sel));
      got_w.delete();
      first_v = -1; done_c = -1;
      base_addr = base; prec = pr; ram_sel = sel; start = 1'b1; out_ready = 1'b1;
      cyc = 0; nrd = 0; nhs = 0; stall = 0; fin = 0; pdata = '0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            chk("busy_c1", 64'(busy), 64'(1));
         end
         if (drop && cyc == 2) begin
            start = 1'b1; base_addr = base + AW'(100); prec = 4'd2; ram_sel = sel + 2'd1;
         end
         if (drop && cyc == 3) start = 1'b0;
         chk("rd_en_win", 64'(rd_en), 64'(cyc <= p));
         if (rd_en) begin
            ea = base + AW'(nrd);
            chk("rd_addr", 64'(rd_addr), 64'(ea));
            nrd++;
         end
         if (stall) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(pdata));
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (rst_after > 0 && nhs == rst_after) begin
            resetn = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            chk("rst_outputs", 64'({busy, done, rd_en, out_valid, rd_addr, out_data}), 64'(0));
            resetn = 1'b1;
            fin = 1;
         end else if (done) begin
            done_c = cyc;
            chk("busy_at_done", 64'(busy), 64'(0));
            chk("hs_count", 64'(nhs), 64'(NW));
            fin = 1;
         end else begin
            case (rmode)
               1:       out_ready = 1'($urandom_range(0, 1));
               2:       out_ready = (first_v < 0) || ((cyc - first_v) % 3 == 0);
               default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
               if (nhs < NW) chk("word", 64'(out_data), 64'(exp_w[nhs]));
               got_w.push_back(out_data);
               nhs++;
            end
            stall = out_valid && !out_ready;
            pdata = out_data;
         end
         if (!fin && cyc > 400) begin
            chk("timeout", 64'(0), 64'(1));
            fin = 1;
         end
      end
      out_ready = 1'b0;
      if (rst_after == 0) begin
         chk("rd_count", 64'(nrd), 64'(p));
         chk("first_valid", 64'(first_v), 64'(p + 2));
         if (rmode == 0) chk("done_cycle", 64'(done_c), 64'(p + 2 + NW));
      end
      if (drop) begin
         repeat (3) begin
            @(negedge clk);
            chk("drop_idle", 64'({busy, rd_en}), 64'(0));
         end
      end
   endtask

   initial begin
      logic [AW-1:0] rb;
      for (int r = 0; r < NR; r++)
         for (int a = 0; a < (1 << AW); a++) mem[r][a] = DW'({$urandom(), $urandom()});

      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({busy, done, rd_en, out_valid, rd_addr, out_data}), 64'(0));
      resetn = 1'b1;
      @(negedge clk);

      // Basic: elem[j] = j+1 in RAM 1 rows 16..23
      for (int b = 0; b < 8; b++)
         for (int j = 0; j < DW; j++) mem[1][16+b][j] = ((j + 1) >> b) & 1;
      run_xfer(9'd16, 4'd8, 2'd1, 0, 0, 0);
      chk("basic_done_c20", 64'(done_c), 64'(20));
      chk("basic_first", 64'(got_w[0]), 64'h04030201);
      chk("basic_last", 64'(got_w[NW-1]), 64'h28272625);

      // Low precision over all-ones rows
      @(negedge clk);
      for (int b = 0; b < 3; b++) mem[2][100+b] = '1;
      run_xfer(9'd100, 4'd3, 2'd2, 0, 0, 0);
      chk("lowp_first_v", 64'(first_v), 64'(5));
      chk("lowp_w0", 64'(got_w[0]), 64'h07070707);
      chk("lowp_w9", 64'(got_w[NW-1]), 64'h07070707);

      // Backpressure
      @(negedge clk);
      run_xfer(9'd200, 4'd8, 2'd0, 2, 0, 0);
      chk("bp_words", 64'(got_w.size()), 64'(NW));

      // Address wrap
      @(negedge clk);
      run_xfer(9'd510, 4'd4, 2'd3, 0, 0, 0);

      // Start during READ is dropped
      @(negedge clk);
      run_xfer(9'd40, 4'd6, 2'd1, 0, 1, 0);

      // Back-to-back: second start lands in the done cycle
      @(negedge clk);
      run_xfer(9'd60, 4'd5, 2'd0, 0, 0, 0);
      run_xfer(9'd70, 4'd0, 2'd2, 1, 0, 0);

      // Reset after three words, then a clean transfer
      @(negedge clk);
      run_xfer(9'd300, 4'd7, 2'd3, 0, 0, 3);
      @(negedge clk);
      run_xfer(9'd300, 4'd7, 2'd3, 0, 0, 0);

      // Randomised transfers
      for (int t = 0; t < 15; t++) begin
         rb = AW'($urandom_range(0, (1 << AW) - 1));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         run_xfer(rb, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 0, 0);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
